sbox_pipe: RTL and testbench

//  Pipelined, multi-lane AES byte substitution engine: LANES bytes per beat, each through

---
 rtl/sbox_pkg.sv | 74 +++++++
 rtl/sbox_pipe_lane.sv | 57 +++++
 rtl/sbox_pipe.sv | 81 ++++++++
 tb/tb_sbox_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_pkg.sv
// Field helpers for the pipelined AES S-box: GF(2^4) mod x^4+x+1, GF((2^4)^2) mod y^2+y+lambda.
// Pure functions only; no latency or backpressure of their own.
// Iso columns are the powers beta^0..beta^7 of a root beta=0x5F of the AES polynomial in the composite field.
package sbox_pkg;

    localparam logic [8:0] GF_POLY    = 9'h11B;
    localparam logic [3:0] GF4_LAMBDA = 4'hC;

    // column i = image of bit i; AES -> composite and composite -> AES
    localparam logic [63:0] ISO_FWD = {8'hD7, 8'h4E, 8'h9B, 8'h44, 8'h2E, 8'h21, 8'h5F, 8'h01};
    localparam logic [63:0] ISO_INV = {8'h32, 8'h4D, 8'h05, 8'h43, 8'hB0, 8'h5D, 8'hE0, 8'h01};

    function automatic logic [7:0] lin_map(input logic [63:0] cols, input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) y = y ^ cols[8*i +: 8];
        end
        return y;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] map_fwd(input logic [7:0] x);
        return lin_map(ISO_FWD, x);
    endfunction

    function automatic logic [7:0] map_inv(input logic [7:0] x);
        return lin_map(ISO_FWD, aff_inv(x));
    endfunction

    function automatic logic [7:0] post_fwd(input logic [7:0] y);
        return aff_fwd(lin_map(ISO_INV, y));
    endfunction

    function automatic logic [7:0] post_inv(input logic [7:0] y);
        return lin_map(ISO_INV, y);
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] s;
        p = '0;
        s = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf4_sq_scale(input logic [3:0] a);
        return gf4_mul(gf4_mul(a, a), GF4_LAMBDA);
    endfunction

    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;  4'h4: r = 4'hD;
            4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;  4'h8: r = 4'hF;
            4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;  4'hC: r = 4'hA;
            4'hD: r = 4'h4;  4'hE: r = 4'h3;  4'hF: r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sbox_pipe_lane.sv
// One byte lane of the S-box pipe: input map -> GF(2^4) inversion -> output map.
// Latency 3 register stages; each stage loads only when its advance enable is high.
// No handshake here: the parent supplies adv1..adv3 and the per-stage modes.
module sbox_pipe_lane
    import sbox_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv1,
    input  logic       adv2,
    input  logic       adv3,
    input  logic       mode1,
    input  logic       mode3,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] s1_q;
    logic [3:0] s2_dinv_q;
    logic [3:0] s2_hi_q;
    logic [3:0] s2_sum_q;
    logic [7:0] s3_q;

    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] d;
    logic [7:0] inv_c;

    // d is the GF(2^4) norm; d=0 only for a zero byte, and inv(0)=0 keeps S(0)=0x63
    always_comb begin
        hi    = s1_q[7:4];
        lo    = s1_q[3:0];
        d     = gf4_sq_scale(hi) ^ gf4_mul(hi, lo) ^ gf4_mul(lo, lo);
        inv_c = {gf4_mul(s2_hi_q, s2_dinv_q), gf4_mul(s2_sum_q, s2_dinv_q)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_dinv_q <= '0;
            s2_hi_q   <= '0;
            s2_sum_q  <= '0;
            s3_q      <= '0;
        end else begin
            if (adv1) s1_q <= mode1 ? map_inv(din) : map_fwd(din);
            if (adv2) begin
                s2_dinv_q <= gf4_inv(d);
                s2_hi_q   <= hi;
                s2_sum_q  <= hi ^ lo;
            end
            if (adv3) s3_q <= mode3 ? post_inv(inv_c) : post_fwd(inv_c);
        end
    end

    assign dout = s3_q;

endmodule

// File: rtl/sbox_pipe.sv
// Multi-lane AES SubBytes/InvSubBytes engine, per-beat mode; optional beat counter under SBOX_PIPE_CNT_EN.
// Latency 3 cycles, 1 beat/cycle; outputs registered.
// Fully stalling: in_ready = combinational advance chain from out_ready, bubbles collapse.
module sbox_pipe
    import sbox_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mode,
    output logic [8*LANES-1:0] out_data,
    output logic [31:0]        xfer_cnt
);

    logic v1, v2, v3;
    logic m1, m2, m3;
    logic adv1, adv2, adv3;

    assign adv3     = !v3 || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;  v2 <= 1'b0;  v3 <= 1'b0;
            m1 <= 1'b0;  m2 <= 1'b0;  m3 <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                m1 <= in_mode;
            end
            if (adv2) begin
                v2 <= v1;
                m2 <= m1;
            end
            if (adv3) begin
                v3 <= v2;
                m3 <= m2;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_pipe_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .adv1  (adv1),
            .adv2  (adv2),
            .adv3  (adv3),
            .mode1 (in_mode),
            .mode3 (m2),
            .din   (in_data[8*g +: 8]),
            .dout  (out_data[8*g +: 8])
        );
    end

    assign out_valid = v3;
    assign out_mode  = m3;

`ifdef SBOX_PIPE_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (v3 && out_ready) cnt_q <= cnt_q + 32'd1;
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_sbox_pipe.sv
// Bench for sbox_pipe: S-box tables derived from plain GF(2^8) arithmetic, queue scoreboard
// checked every cycle, plus directed beats with literal FIPS-197 values.
module tb_sbox_pipe;
    import sbox_pkg::GF_POLY;

    localparam int LANES = 4;
    localparam int W     = 8 * LANES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_mode = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_mode;
    logic [W-1:0] out_data;
    logic [31:0]  xfer_cnt;

    always #5 clk = ~clk;

    sbox_pipe #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    typedef struct {
        logic         mode;
        logic [W-1:0] dat;
        int           cyc;
    } beat_t;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           popped = 0;
    int           pushed = 0;
    int           last_lat = 0;
    logic [31:0]  xfer_exp = '0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_dat = '0;
    logic         prev_mode = 1'b0;
    logic [7:0]   sfwd [256];
    logic [7:0]   sinv [256];
    beat_t        q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] affine_f(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return r;
    endfunction

    function automatic logic [7:0] affine_i(input logic [7:0] s);
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h05;
        for (int i = 0; i < 8; i++)
            r[i] = s[(i+2)%8] ^ s[(i+5)%8] ^ s[(i+7)%8] ^ c[i];
        return r;
    endfunction

    function automatic logic [W-1:0] model_sub(input logic m, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++)
            r[8*k +: 8] = m ? sinv[d[8*k +: 8]] : sfwd[d[8*k +: 8]];
        return r;
    endfunction

    // one cycle: drive at the falling edge, check settled outputs, score the upcoming edge
    task automatic step(input logic r, input logic iv, input logic im,
                        input logic [W-1:0] id, input logic ordy);
        beat_t b;
        @(negedge clk);
        rst = r;  in_valid = iv;  in_mode = im;  in_data = id;  out_ready = ordy;
        #1;
        cyc++;
        if (r) begin
            q.delete();
            xfer_exp  = '0;
            prev_hold = 1'b0;
            return;
        end
        chk("in_ready", 64'(in_ready), 64'((q.size() < 3) || ordy));
`ifdef SBOX_PIPE_CNT_EN
        chk("xfer_cnt", 64'(xfer_cnt), 64'(xfer_exp));
`else
        chk("xfer_cnt_tied", 64'(xfer_cnt), 64'd0);
`endif
        if (prev_hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(prev_dat));
            chk("hold_mode", 64'(out_mode), 64'(prev_mode));
        end
        if (q.size() == 0) chk("idle_out_valid", 64'(out_valid), 64'd0);
        if (out_valid && q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].dat));
            chk("out_mode", 64'(out_mode), 64'(q[0].mode));
            if (ordy) begin
                b = q.pop_front();
                last_lat = cyc - b.cyc;
                popped++;
                xfer_exp = xfer_exp + 32'd1;
            end
        end
        prev_hold = out_valid && !ordy;
        prev_dat  = out_data;
        prev_mode = out_mode;
        if (iv && in_ready) begin
            b.mode = im;
            b.dat  = model_sub(im, id);
            b.cyc  = cyc;
            q.push_back(b);
            pushed++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++)
            step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int p0;
        int n;

        for (int x = 0; x < 256; x++) begin
            sfwd[x] = affine_f(ginv(8'(x)));
            sinv[x] = ginv(affine_i(8'(x)));
        end
        chk("model_s53", 64'(sfwd[8'h53]), 64'hED);
        chk("model_s00", 64'(sfwd[8'h00]), 64'h63);
        chk("model_i16", 64'(sinv[8'h16]), 64'hFF);
        n = 0;
        for (int x = 0; x < 256; x++)
            if (sinv[sfwd[x]] != 8'(x)) n++;
        chk("model_roundtrip", 64'(n), 64'd0);

        // reset state
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_mode", 64'(out_mode), 64'd0);
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // forward beat, latency 3
        step(1'b0, 1'b1, 1'b0, 32'h5301_00FF, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("fwd_not_early", 64'(out_valid), 64'd0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("fwd_valid", 64'(out_valid), 64'd1);
        chk("fwd_data", 64'(out_data), 64'hED7C_6316);
        chk("fwd_latency", 64'(last_lat), 64'd3);

        // inverse beat
        step(1'b0, 1'b1, 1'b1, 32'h1663_7CED, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("inv_data", 64'(out_data), 64'hFF00_0153);
        chk("inv_mode", 64'(out_mode), 64'd1);

        // mixed modes back to back
        for (int i = 0; i < 24; i++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), W'($urandom), 1'b1);
        drain();

        // backpressure: fill, stall 5 cycles, release
        p0 = popped;
        step(1'b0, 1'b1, 1'b0, 32'h0011_2233, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h4455_6677, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h8899_AABB, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b1, W'($urandom), 1'b0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_data), 64'({sfwd[8'h00], sfwd[8'h11], sfwd[8'h22], sfwd[8'h33]}));
        drain();
        chk("bp_count", 64'(popped - p0), 64'd3);

        // reset with two beats in flight
        step(1'b0, 1'b1, 1'b0, W'($urandom), 1'b0);
        step(1'b0, 1'b1, 1'b1, W'($urandom), 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", 64'(out_data), 64'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // exhaustive lane 0, both modes
        for (int x = 0; x < 256; x++)
            for (int m = 0; m < 2; m++)
                step(1'b0, 1'b1, 1'(m), {24'($urandom), 8'(x)}, 1'b1);
        drain();

        // random traffic with stalls
        for (int i = 0; i < 400; i++)
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 W'($urandom), 1'($urandom_range(0, 9) < 7));
        drain();

        // counter: 10 beats after reset under random stalls
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        p0 = pushed;
        for (int i = 0; i < 200 && pushed - p0 < 10; i++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
        drain();
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
`ifdef SBOX_PIPE_CNT_EN
        chk("cnt_ten", 64'(xfer_cnt), 64'd10);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        xfer_exp = 32'hFFFF_FFFF;
        step(1'b0, 1'b1, 1'b0, W'($urandom), 1'b1);
        drain();
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("cnt_wrap", 64'(xfer_cnt), 64'd0);
`else
        chk("cnt_off", 64'(xfer_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
